// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback interface of the register hazard scoreboard.
// master: decode/writeback side (drives instruction and retire information,
//         observes the stall and status outputs).
// slave : the scoreboard itself.
// Inputs : id_valid, src1, use_src1, src2, Two_src, issue_dest, issue_wb_en,
//          flush, freeze, WB_WB_en, WB_Dest
// Outputs: Hazard (combinational stall), busy_vec, stall_count,
//          err_overflow, err_underflow
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [3:0]  src1;
  logic        use_src1;
  logic [3:0]  src2;
  logic        Two_src;
  logic [3:0]  issue_dest;
  logic        issue_wb_en;
  logic        flush;
  logic        freeze;
  logic        WB_WB_en;
  logic [3:0]  WB_Dest;
  logic        Hazard;
  logic [15:0] busy_vec;
  logic [15:0] stall_count;
  logic        err_overflow;
  logic        err_underflow;

  modport master (
    output id_valid, src1, use_src1, src2, Two_src, issue_dest, issue_wb_en,
           flush, freeze, WB_WB_en, WB_Dest,
    input  Hazard, busy_vec, stall_count, err_overflow, err_underflow
  );

  modport slave (
    input  id_valid, src1, use_src1, src2, Two_src, issue_dest, issue_wb_en,
           flush, freeze, WB_WB_en, WB_Dest,
    output Hazard, busy_vec, stall_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for a five-stage pipeline.
// Keeps a 2-bit pending-write count per architectural register (R0..R15,
// R15 included), raises Hazard when the instruction in decode reads a
// register with a write still in flight, and counts stall cycles.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   sb  : hazard_scoreboard_if.slave (decode, writeback and status signals)
module hazard_scoreboard (
  input  logic                  clk,
  input  logic                  rst,
  hazard_scoreboard_if.slave    sb
);

  logic [1:0]  r_cnt [16];
  logic [15:0] r_stall_count;
  logic        r_err_overflow;
  logic        r_err_underflow;

  logic [15:0] w_retire_hit;
  logic [15:0] w_pending_eff;
  logic [15:0] w_issue_hit;
  logic [15:0] w_busy;
  logic        w_hazard;
  logic        w_issue;

  // NOTE: every signal written in an always_comb gets a value on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_retire_hit  = '0;
    w_pending_eff = '0;
    w_busy        = '0;
    for (int i = 0; i < 16; i++) begin
      w_retire_hit[i]  = sb.WB_WB_en && (sb.WB_Dest == 4'(i));
      // A writeback this cycle is forwarded through the register file, so the
      // effective count is cnt - hit; it is nonzero exactly when cnt > hit.
      w_pending_eff[i] = r_cnt[i] > {1'b0, w_retire_hit[i]};
      // busy_vec shows the stored counts only; no writeback bypass here.
      w_busy[i]        = r_cnt[i] != 2'd0;
    end
  end

  // Hazard ignores freeze on purpose: a frozen cycle that would also stall on
  // a dependency still counts as a stall cycle.
  assign w_hazard = sb.id_valid && !rst &&
                    ((sb.use_src1 && w_pending_eff[sb.src1]) ||
                     (sb.Two_src  && w_pending_eff[sb.src2]));

  // A squashed (flush) or held (freeze) instruction must not claim a pending
  // write, otherwise its count would never be retired.
  assign w_issue = sb.id_valid && sb.issue_wb_en && !w_hazard &&
                   !sb.freeze && !sb.flush;

  always_comb begin
    w_issue_hit = '0;
    for (int i = 0; i < 16; i++) begin
      w_issue_hit[i] = w_issue && (sb.issue_dest == 4'(i));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the count array is sixteen small flop pairs, not a RAM, so it is
      // cleared by reset like any other state; a mid-run reset discards all
      // pending writes.
      for (int i = 0; i < 16; i++) begin
        r_cnt[i] <= 2'd0;
      end
      r_stall_count   <= 16'd0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        // Issue and retire to the same register in one cycle cancel out.
        case ({w_issue_hit[i], w_retire_hit[i]})
          2'b10: begin
            if (r_cnt[i] == 2'd3) r_err_overflow <= 1'b1;
            else                  r_cnt[i]       <= r_cnt[i] + 2'd1;
          end
          2'b01: begin
            if (r_cnt[i] == 2'd0) r_err_underflow <= 1'b1;
            else                  r_cnt[i]        <= r_cnt[i] - 2'd1;
          end
          default: ;
        endcase
      end
      if (w_hazard && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign sb.Hazard        = w_hazard;
  assign sb.busy_vec      = w_busy;
  assign sb.stall_count   = r_stall_count;
  assign sb.err_overflow  = r_err_overflow;
  assign sb.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Each scenario task drives the
// decode/writeback inputs, pushes the expected status snapshot
// {Hazard, err_overflow, err_underflow, busy_vec, stall_count} to a queue,
// then pops it and compares against the DUT when the state is observable.
module tb_hazard_scoreboard;

  typedef struct {
    string       name;
    logic [34:0] val;
  } exp_t;

  logic clk;
  logic rst;
  hazard_scoreboard_if sb ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        e;
  logic [34:0] obs;
  int          vectors     = 0;
  int          miscompares = 0;

  // Running expectations for the accumulated status outputs.
  logic [15:0] exp_stall = 16'd0;
  logic        exp_ovf   = 1'b0;
  logic        exp_unf   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.id_valid    = 1'b0;
    sb.src1        = 4'd0;
    sb.use_src1    = 1'b0;
    sb.src2        = 4'd0;
    sb.Two_src     = 1'b0;
    sb.issue_dest  = 4'd0;
    sb.issue_wb_en = 1'b0;
    sb.flush       = 1'b0;
    sb.freeze      = 1'b0;
    sb.WB_WB_en    = 1'b0;
    sb.WB_Dest     = 4'd0;
  endtask

  task automatic issue(input logic [3:0] dest);
    idle();
    sb.id_valid    = 1'b1;
    sb.issue_wb_en = 1'b1;
    sb.issue_dest  = dest;
  endtask

  task automatic retire(input logic [3:0] dest);
    idle();
    sb.WB_WB_en = 1'b1;
    sb.WB_Dest  = dest;
  endtask

  // Scoreboard push: records what the DUT should show at the next sample.
  task automatic expect_state(input string name, input logic h, input logic [15:0] busy);
    exp_t x;
    x.name = name;
    x.val  = {h, exp_ovf, exp_unf, busy, exp_stall};
    exp_q.push_back(x);
  endtask

  function automatic logic [34:0] snap();
    return {sb.Hazard, sb.err_overflow, sb.err_underflow, sb.busy_vec, sb.stall_count};
  endfunction

  task automatic test_reset();
    idle();
    rst            = 1'b1;
    sb.id_valid    = 1'b1;
    sb.use_src1    = 1'b1;
    sb.issue_wb_en = 1'b1;
    sb.issue_dest  = 4'd3;
    sb.WB_WB_en    = 1'b1;
    sb.WB_Dest     = 4'd9;
    expect_state("reset_hold", 1'b0, 16'h0000);
    tick();
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    rst = 1'b0;
    idle();
    expect_state("reset_release", 1'b0, 16'h0000);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_raw_stall();
    issue(4'd3);
    tick();
    idle();
    sb.id_valid = 1'b1;
    sb.use_src1 = 1'b1;
    sb.src1     = 4'd3;
    expect_state("raw_hazard_raised", 1'b1, 16'h0008);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    tick();
    tick();
    exp_stall = 16'd2;
    expect_state("raw_stall_two_cycles", 1'b1, 16'h0008);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    // Writeback of R3 in the same cycle releases the stall immediately.
    sb.WB_WB_en = 1'b1;
    sb.WB_Dest  = 4'd3;
    expect_state("raw_wb_bypass", 1'b0, 16'h0008);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    tick();
    idle();
    expect_state("raw_retired", 1'b0, 16'h0000);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_same_cycle();
    issue(4'd5);
    expect_state("r5_issued", 1'b0, 16'h0020);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    issue(4'd5);
    sb.WB_WB_en = 1'b1;
    sb.WB_Dest  = 4'd5;
    expect_state("r5_issue_and_retire", 1'b0, 16'h0020);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    retire(4'd5);
    expect_state("r5_retired", 1'b0, 16'h0000);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_flush_freeze();
    issue(4'd2);
    sb.flush = 1'b1;
    expect_state("r2_flushed", 1'b0, 16'h0000);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    issue(4'd2);
    sb.freeze = 1'b1;
    expect_state("r2_frozen", 1'b0, 16'h0000);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_two_src();
    issue(4'd7);
    tick();
    idle();
    sb.id_valid = 1'b1;
    sb.use_src1 = 1'b1;
    sb.src1     = 4'd0;
    sb.src2     = 4'd7;
    sb.Two_src  = 1'b0;
    expect_state("src2_ignored", 1'b0, 16'h0080);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    sb.Two_src = 1'b1;
    expect_state("src2_hazard", 1'b1, 16'h0080);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    // Frozen cycle with a dependency still counts one stall.
    sb.freeze = 1'b1;
    tick();
    exp_stall = exp_stall + 16'd1;
    expect_state("frozen_stall_counted", 1'b1, 16'h0080);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    retire(4'd7);
    expect_state("r7_retired", 1'b0, 16'h0000);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_overflow_underflow();
    for (int k = 0; k < 3; k++) begin
      issue(4'd4);
      tick();
    end
    idle();
    expect_state("r4_count_3", 1'b0, 16'h0010);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    issue(4'd4);
    tick();
    idle();
    exp_ovf = 1'b1;
    expect_state("r4_overflow", 1'b0, 16'h0010);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    retire(4'd9);
    tick();
    idle();
    exp_unf = 1'b1;
    expect_state("r9_underflow", 1'b0, 16'h0010);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    // Saturated count holds exactly 3: two retires leave R4 busy, the third clears it.
    retire(4'd4);
    tick();
    retire(4'd4);
    tick();
    idle();
    expect_state("r4_one_left", 1'b0, 16'h0010);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    retire(4'd4);
    tick();
    idle();
    expect_state("r4_drained", 1'b0, 16'h0000);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    issue(4'd1);
    tick();
    issue(4'd8);
    tick();
    issue(4'd15);
    tick();
    idle();
    sb.id_valid = 1'b1;
    sb.use_src1 = 1'b1;
    sb.src1     = 4'd8;
    expect_state("pending_r1_r8_r15", 1'b1, 16'h8102);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    rst = 1'b1;
    expect_state("rst_masks_hazard", 1'b0, 16'h8102);
    #1;
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    tick();
    exp_stall = 16'd0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    expect_state("mid_reset_cleared", 1'b0, 16'h0000);
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    rst = 1'b0;
    issue(4'd6);
    expect_state("first_edge_after_reset", 1'b0, 16'h0040);
    tick();
    obs = snap(); e = exp_q.pop_front(); vectors++;
    if (obs !== e.val) begin
      $display("FAIL %s: got %h want %h", e.name, obs, e.val); miscompares++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_same_cycle();
    test_flush_freeze();
    test_two_src();
    test_overflow_underflow();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
